// File: rtl/tmr_pkg.sv
// Shared types, default parameters and helpers for the TMR fault manager.
// The saturating increment works on a 32-bit container; callers pass
// their real width so counters of up to 32 bits are supported.
package tmr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONFIRM,
      RESYNC,
      CHECK,
      FATAL
   } tmr_fault_state_e;

   localparam int DEF_NUM_VOTERS     = 4;
   localparam int DEF_CONFIRM_CYCLES = 2;
   localparam int DEF_RESYNC_CYCLES  = 2;
   localparam int DEF_MAX_RETRIES    = 3;
   localparam int DEF_CNT_W          = 16;

   // Returns val + 1 unless val already holds the all-ones value of a
   // w-bit counter, in which case val is returned unchanged (no wrap).
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int w);
      logic [31:0] max_val;
      if (w >= 32) begin
         max_val = '1;
      end else begin
         max_val = (32'd1 << w) - 32'd1;
      end
      if (val >= max_val) begin
         return val;
      end else begin
         return val + 32'd1;
      end
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Used for the fault-event count so it sticks at all-ones instead of
// wrapping back to a misleadingly small number.
module sat_counter
   import tmr_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   // Counter register: reset and clear zero it, otherwise saturating increment
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= W'(sat_inc(32'(cnt), W));
      end
   end

endmodule

// File: rtl/tmr_fault_manager.sv
// Supervisor for the err flags of a group of TMR majority voters.
// A disagreement must persist for CONFIRM_CYCLES before the replicas are
// reloaded with a resync_o pulse of RESYNC_CYCLES; a disagreement that
// survives MAX_RETRIES resyncs escalates to a sticky fatal flag.
// Optional build macro: TMR_FAULT_INJECT_EN adds inject_i, which is ORed
// into err_i ahead of all logic for on-silicon self-test.
module tmr_fault_manager
   import tmr_pkg::*;
#(
   parameter int NUM_VOTERS     = DEF_NUM_VOTERS,
   parameter int CONFIRM_CYCLES = DEF_CONFIRM_CYCLES,
   parameter int RESYNC_CYCLES  = DEF_RESYNC_CYCLES,
   parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_VOTERS-1:0] err_i,
`ifdef TMR_FAULT_INJECT_EN
   input  logic [NUM_VOTERS-1:0] inject_i,
`endif
   input  logic                  clear_i,
   output logic                  resync_o,
   output logic                  busy_o,
   output logic                  fatal_o,
   output logic [NUM_VOTERS-1:0] fault_vec_o,
   output logic [CNT_W-1:0]      fault_cnt_o
);

   localparam int CONF_W  = $clog2(CONFIRM_CYCLES + 1);
   localparam int RS_W    = $clog2(RESYNC_CYCLES + 1);
   localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

   localparam logic [CONF_W-1:0]  CONF_LAST  = CONF_W'(CONFIRM_CYCLES - 1);
   localparam logic [RS_W-1:0]    RS_LAST    = RS_W'(RESYNC_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

   tmr_fault_state_e      state_q, state_d;
   logic [CONF_W-1:0]     conf_q, conf_d;
   logic [RS_W-1:0]       rs_q, rs_d;
   logic [RETRY_W-1:0]    retry_q, retry_d;
   logic [NUM_VOTERS-1:0] err_eff;
   logic                  err_any;
   logic                  cnt_inc;

`ifdef TMR_FAULT_INJECT_EN
   assign err_eff = err_i | inject_i;
`else
   assign err_eff = err_i;
`endif

   assign err_any = |err_eff;

   // Next-state logic: confirm, resync, check and escalate sequence
   always_comb begin
      state_d = state_q;
      conf_d  = conf_q;
      rs_d    = rs_q;
      retry_d = retry_q;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (err_any && !clear_i) begin
               cnt_inc = 1'b1;
               conf_d  = CONF_W'(1);
               rs_d    = '0;
               if (CONFIRM_CYCLES == 1) begin
                  state_d = RESYNC;
               end else begin
                  state_d = CONFIRM;
               end
            end
         end
         CONFIRM: begin
            if (!err_any) begin
               state_d = IDLE;
               conf_d  = '0;
            end else if (conf_q == CONF_LAST) begin
               state_d = RESYNC;
               conf_d  = '0;
               rs_d    = '0;
            end else begin
               conf_d = conf_q + CONF_W'(1);
            end
         end
         RESYNC: begin
            if (rs_q == RS_LAST) begin
               state_d = CHECK;
               rs_d    = '0;
            end else begin
               rs_d = rs_q + RS_W'(1);
            end
         end
         CHECK: begin
            if (!err_any) begin
               state_d = IDLE;
               retry_d = '0;
            end else if (retry_q == RETRY_LAST) begin
               state_d = FATAL;
               retry_d = retry_q + RETRY_W'(1);
            end else begin
               state_d = RESYNC;
               retry_d = retry_q + RETRY_W'(1);
               rs_d    = '0;
            end
         end
         FATAL: begin
            if (clear_i) begin
               state_d = IDLE;
               retry_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            conf_d  = '0;
            rs_d    = '0;
            retry_d = '0;
         end
      endcase
   end

   // State and sequencing counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         conf_q  <= '0;
         rs_q    <= '0;
         retry_q <= '0;
      end else begin
         state_q <= state_d;
         conf_q  <= conf_d;
         rs_q    <= rs_d;
         retry_q <= retry_d;
      end
   end

   // Status outputs are flopped from the next state so none of them sees a combinational input path
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resync_o <= 1'b0;
         busy_o   <= 1'b0;
         fatal_o  <= 1'b0;
      end else begin
         resync_o <= (state_d == RESYNC);
         busy_o   <= (state_d == CONFIRM) || (state_d == RESYNC) || (state_d == CHECK);
         fatal_o  <= (state_d == FATAL);
      end
   end

   // Sticky per-voter record; a clear request wins over new flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fault_vec_o <= '0;
      end else if (clear_i) begin
         fault_vec_o <= '0;
      end else begin
         fault_vec_o <= fault_vec_o | err_eff;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_fault_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc),
      .clr   (clear_i),
      .cnt   (fault_cnt_o)
   );

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Self-checking bench for tmr_fault_manager. Two instances share the
// stimulus: one with default parameters and one with a 2-bit counter so
// saturation is reachable. Expected values come from an event-level
// model of the supervision rules kept below.
module tb_tmr_fault_manager;

   localparam int NV    = 4;
   localparam int CONF  = 2;
   localparam int RS    = 2;
   localparam int MAXR  = 3;

   logic          clk;
   logic          rst_n;
   logic [NV-1:0] err;
   logic [NV-1:0] inj;
   logic          clr;

   logic          resync_a, busy_a, fatal_a;
   logic [NV-1:0] vec_a;
   logic [15:0]   cnt_a;
   logic          resync_b, busy_b, fatal_b;
   logic [NV-1:0] vec_b;
   logic [1:0]    cnt_b;

   int total = 0;
   int bad   = 0;

   // Reference model state: streak of confirming cycles, resync cycles
   // still owed, pending check, retries used, and the status record.
   int            m_streak, m_pulse, m_retries, m_cnt16, m_cnt2;
   bit            m_check, m_fatal;
   logic [NV-1:0] m_vec;

   tmr_fault_manager dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .err_i       (err),
`ifdef TMR_FAULT_INJECT_EN
      .inject_i    (inj),
`endif
      .clear_i     (clr),
      .resync_o    (resync_a),
      .busy_o      (busy_a),
      .fatal_o     (fatal_a),
      .fault_vec_o (vec_a),
      .fault_cnt_o (cnt_a)
   );

   tmr_fault_manager #(.CNT_W(2)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .err_i       (err),
`ifdef TMR_FAULT_INJECT_EN
      .inject_i    (inj),
`endif
      .clear_i     (clr),
      .resync_o    (resync_b),
      .busy_o      (busy_b),
      .fatal_o     (fatal_b),
      .fault_vec_o (vec_b),
      .fault_cnt_o (cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] act_word();
      return {resync_a, busy_a, fatal_a, vec_a, cnt_a, resync_b, busy_b, fatal_b, vec_b, cnt_b};
   endfunction

   function automatic logic [31:0] exp_word();
      logic busy;
      logic rs;
      busy = (m_streak > 0) || (m_pulse > 0) || m_check;
      rs   = (m_pulse > 0);
      return {rs, busy, m_fatal, m_vec, 16'(m_cnt16), rs, busy, m_fatal, m_vec, 2'(m_cnt2)};
   endfunction

   // Advance the behavioural model by one clock edge
   task automatic model_step(input logic r, input logic [NV-1:0] e, input logic c);
      bit any;
      any = (e != '0);
      if (!r) begin
         m_vec = '0; m_cnt16 = 0; m_cnt2 = 0; m_streak = 0; m_pulse = 0;
         m_check = 0; m_retries = 0; m_fatal = 0;
         return;
      end
      if (m_fatal) begin
         if (c) begin
            m_fatal   = 0;
            m_retries = 0;
         end
      end else if (m_pulse > 0) begin
         m_pulse--;
         if (m_pulse == 0) m_check = 1;
      end else if (m_check) begin
         m_check = 0;
         if (any) begin
            m_retries++;
            if (m_retries == MAXR) m_fatal = 1;
            else m_pulse = RS;
         end else begin
            m_retries = 0;
         end
      end else if (m_streak > 0) begin
         if (!any) begin
            m_streak = 0;
         end else begin
            m_streak++;
            if (m_streak == CONF) begin
               m_streak = 0;
               m_pulse  = RS;
            end
         end
      end else if (any && !c) begin
         if (m_cnt16 < 65535) m_cnt16++;
         if (m_cnt2 < 3) m_cnt2++;
         m_streak = 1;
         if (m_streak == CONF) begin
            m_streak = 0;
            m_pulse  = RS;
         end
      end
      if (c) begin
         m_vec = '0; m_cnt16 = 0; m_cnt2 = 0;
      end else begin
         m_vec = m_vec | e;
      end
   endtask

   // One cycle of stimulus: drive, clock, update model, settle at the falling edge
   task automatic applyStimulus(input logic r, input logic [NV-1:0] e, input logic c);
      rst_n = r;
      err   = e;
      clr   = c;
      @(posedge clk);
      model_step(r, e | inj, c);
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 4'b1111, 1'b0);
         total++;
         if (act_word() !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset cyc%0d got=%h want=%h", i, act_word(), 32'h0);
         end
      end
   endtask

   task automatic test_transient();
      applyStimulus(1'b0, '0, 1'b0);
      applyStimulus(1'b1, 4'b0010, 1'b0);
      total++;
      if (busy_a !== 1'b1) begin
         bad++;
         $display("[TB] FAIL transient_busy got=%b want=1", busy_a);
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 4'b0000, 1'b0);
         total++;
         if (act_word() !== exp_word()) begin
            bad++;
            $display("[TB] FAIL transient cyc%0d got=%h want=%h", i, act_word(), exp_word());
         end
         total++;
         if (resync_a !== 1'b0 || busy_a !== 1'b0) begin
            bad++;
            $display("[TB] FAIL transient_quiet cyc%0d got=%b%b want=00", i, resync_a, busy_a);
         end
      end
      total++;
      if (cnt_a !== 16'd1 || vec_a !== 4'b0010) begin
         bad++;
         $display("[TB] FAIL transient_status got=%0d/%b want=1/0010", cnt_a, vec_a);
      end
   endtask

   task automatic test_recovered();
      int seen;
      seen = 0;
      applyStimulus(1'b0, '0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, (i < 2) ? 4'b0001 : 4'b0000, 1'b0);
         if (resync_a === 1'b1) seen++;
         total++;
         if (act_word() !== exp_word()) begin
            bad++;
            $display("[TB] FAIL recovered cyc%0d got=%h want=%h", i, act_word(), exp_word());
         end
      end
      total++;
      if (seen != RS || fatal_a !== 1'b0 || cnt_a !== 16'd1 || busy_a !== 1'b0) begin
         bad++;
         $display("[TB] FAIL recovered_summary got=rs%0d f%b c%0d b%b want=rs2 f0 c1 b0",
                  seen, fatal_a, cnt_a, busy_a);
      end
   endtask

   task automatic test_persistent();
      int seen;
      seen = 0;
      applyStimulus(1'b0, '0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 4'b1000, 1'b0);
         if (resync_a === 1'b1) seen++;
         total++;
         if (act_word() !== exp_word()) begin
            bad++;
            $display("[TB] FAIL persistent cyc%0d got=%h want=%h", i, act_word(), exp_word());
         end
      end
      total++;
      if (seen != 3 * RS || fatal_a !== 1'b1 || resync_a !== 1'b0 || cnt_a !== 16'd1) begin
         bad++;
         $display("[TB] FAIL persistent_summary got=rs%0d f%b r%b c%0d want=rs6 f1 r0 c1",
                  seen, fatal_a, resync_a, cnt_a);
      end
      applyStimulus(1'b1, 4'b0000, 1'b1);
      total++;
      if (act_word() !== 32'h0) begin
         bad++;
         $display("[TB] FAIL fatal_clear got=%h want=%h", act_word(), 32'h0);
      end
   endtask

   task automatic test_saturation();
      applyStimulus(1'b0, '0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 4'b0001, 1'b0);
         applyStimulus(1'b1, 4'b0000, 1'b0);
      end
      total++;
      if (cnt_b !== 2'd3 || cnt_a !== 16'd5) begin
         bad++;
         $display("[TB] FAIL saturation got=%0d/%0d want=3/5", cnt_b, cnt_a);
      end
      applyStimulus(1'b1, 4'b1111, 1'b1);
      total++;
      if (act_word() !== 32'h0) begin
         bad++;
         $display("[TB] FAIL idle_clear got=%h want=%h", act_word(), 32'h0);
      end
      applyStimulus(1'b1, 4'b0000, 1'b0);
      total++;
      if (act_word() !== exp_word() || busy_a !== 1'b0) begin
         bad++;
         $display("[TB] FAIL idle_clear_after got=%h want=%h", act_word(), exp_word());
      end
   endtask

   task automatic test_random();
      logic [NV-1:0] e;
      logic          c, r;
      applyStimulus(1'b0, '0, 1'b0);
      for (int i = 0; i < 600; i++) begin
         e = ($urandom_range(0, 2) == 0) ? NV'($urandom) : '0;
         c = ($urandom_range(0, 15) == 0);
         r = ($urandom_range(0, 63) != 0);
         applyStimulus(r, e, c);
         total++;
         if (act_word() !== exp_word()) begin
            bad++;
            $display("[TB] FAIL random cyc%0d got=%h want=%h", i, act_word(), exp_word());
         end
      end
   endtask

`ifdef TMR_FAULT_INJECT_EN
   task automatic test_inject();
      int seen;
      seen = 0;
      applyStimulus(1'b0, '0, 1'b0);
      inj = 4'b0100;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 4'b0000, 1'b0);
         if (resync_a === 1'b1) seen++;
         total++;
         if (act_word() !== exp_word()) begin
            bad++;
            $display("[TB] FAIL inject cyc%0d got=%h want=%h", i, act_word(), exp_word());
         end
      end
      total++;
      if (seen != 3 * RS || fatal_a !== 1'b1 || vec_a !== 4'b0100) begin
         bad++;
         $display("[TB] FAIL inject_summary got=rs%0d f%b v%b want=rs6 f1 v0100",
                  seen, fatal_a, vec_a);
      end
      inj = '0;
      applyStimulus(1'b0, '0, 1'b0);
   endtask
`endif

   // Test sequence
   initial begin
      rst_n = 1'b0;
      err   = '0;
      inj   = '0;
      clr   = 1'b0;
      m_vec = '0; m_cnt16 = 0; m_cnt2 = 0; m_streak = 0; m_pulse = 0;
      m_check = 0; m_retries = 0; m_fatal = 0;
      @(negedge clk);
      test_reset();
      test_transient();
      test_recovered();
      test_persistent();
      test_saturation();
`ifdef TMR_FAULT_INJECT_EN
      test_inject();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
